branch_sequencer: RTL and testbench
===================================

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 Parameter PC_WIDTH, default 8, SHALL set the program-counter width in bits.
REQ-002 Parameter RESET_PC, default 0, SHALL set the PC value loaded on reset and restart.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  single-cycle pulse that begins or restarts sequencing.
REQ-006 instr_valid  input  1  upstream instruction fields valid.
REQ-007 instr_ready  output  1  sequencer accepts an instruction this cycle.
REQ-008 instr_branch  input  1  accepted instruction is a branch.
REQ-009 instr_halt  input  1  accepted instruction is a halt.
REQ-010 instr_cmp  input  2  branch condition: 0 a<b, 1 a>b, 2 a==b, 3 unconditional.
REQ-011 instr_offset  input  8  signed branch displacement.
REQ-012 compare_control  output  2  registered condition driven to the signed 16-bit comparator.
REQ-013 cmp_result  input  1  comparator result, combinational from compare_control.
REQ-014 pc  output  PC_WIDTH  current program counter.
REQ-015 taken  output  1  one-cycle pulse when a branch is taken.
REQ-016 halted  output  1  high while in HALTED.
REQ-017 taken_count  output  16  taken-branch counter (see Configuration).

Function
REQ-018 FSM states SHALL be IDLE, RUN, EVAL and HALTED.
REQ-019 IDLE: instr_ready=0 and pc held; start SHALL move to RUN with pc=RESET_PC.
REQ-020 RUN: instr_ready=1; an instruction SHALL be accepted only when instr_valid and instr_ready are both 1.
REQ-021 RUN accept with instr_halt=1 SHALL go to HALTED with pc unchanged; halt SHALL take priority over instr_branch.
REQ-022 RUN accept with instr_branch=0 SHALL set pc<=pc+1 and stay in RUN, sustaining one instruction per cycle.
REQ-023 RUN accept with instr_branch=1 SHALL register compare_control<=instr_cmp and the offset, then go to EVAL.
REQ-024 EVAL: instr_ready=0; cmp_result SHALL be sampled at the end of the EVAL cycle, giving a branch latency of 2 cycles from acceptance to the pc update.
REQ-025 EVAL with cmp_result=1, or with registered condition 3 regardless of cmp_result, SHALL set pc<=pc+sign_extend(offset), pulse taken the next cycle, and return to RUN.
REQ-026 EVAL otherwise SHALL set pc<=pc+1 and return to RUN with taken=0.
REQ-027 PC arithmetic SHALL be modulo 2^PC_WIDTH, so forward and backward branches wrap silently.
REQ-028 compare_control SHALL hold its value outside EVAL until the next branch is accepted.
REQ-029 HALTED: halted=1 and instr_ready=0; start SHALL restart in RUN with pc=RESET_PC.
REQ-030 start asserted in RUN or EVAL SHALL override the current operation: pc=RESET_PC, state RUN, any pending branch discarded, taken=0.

Reset
REQ-031 When rst_n=0, the block SHALL asynchronously set state=IDLE, pc=RESET_PC, compare_control=0, taken=0, halted=0, taken_count=0 and instr_ready=0.
REQ-032 Reset asserted mid-EVAL SHALL discard the pending branch; after reset release, the block SHALL ignore all inputs except start.

Configuration
REQ-033 With macro BRANCH_COUNT_EN defined, taken_count SHALL increment on each taken pulse and saturate at 16'hFFFF; it SHALL clear only on reset.
REQ-034 Without BRANCH_COUNT_EN, taken_count SHALL be tied to 0 and no counter logic SHALL be generated.

Verification
REQ-035 Reset then start, with 3 non-branch instructions accepted back-to-back -> pc 0,1,2,3 on consecutive cycles.
REQ-036 At pc=5, accept a branch with instr_cmp=0, offset=-3, cmp_result=1 -> compare_control=0 in EVAL, then pc=2 and a one-cycle taken pulse.
REQ-037 At pc=5, accept a branch with instr_cmp=2, offset=+4, cmp_result=0 -> pc=6 and taken stays 0.
REQ-038 PC_WIDTH=8, at pc=250, accept a branch with instr_cmp=3, offset=+10 -> pc=4 (wrap) and taken=1.
REQ-039 Accept an instruction with instr_halt=1 and instr_branch=1 -> halted=1, pc unchanged, instr_ready=0; a later start -> pc=RESET_PC and RUN.
REQ-040 BRANCH_COUNT_EN defined, 3 taken and 2 untaken branches -> taken_count=3; rst_n pulsed low in EVAL -> all outputs at reset values immediately.

Source files
------------

// File: rtl/branch_sequencer.sv
// Branch sequencer: walks a PC through RUN/EVAL/HALTED, resolving branches one cycle after acceptance.
// Optional macro BRANCH_COUNT_EN adds a saturating taken-branch counter on taken_count.
module branch_sequencer #(
  parameter int PC_WIDTH = 8,
  parameter int RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic                instr_branch,
  input  logic                instr_halt,
  input  logic [1:0]          instr_cmp,
  input  logic [7:0]          instr_offset,
  output logic [1:0]          compare_control,
  input  logic                cmp_result,
  output logic [PC_WIDTH-1:0] pc,
  output logic                taken,
  output logic                halted,
  output logic [15:0]         taken_count
);

  typedef enum logic [1:0] {IDLE, RUN, EVAL, HALTED} state_t;

  localparam logic [PC_WIDTH-1:0] PC_RST     = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] PC_ONE     = PC_WIDTH'(1);
  localparam logic [1:0]          CMP_ALWAYS = 2'd3;

  state_t                 state, state_nxt;
  logic [PC_WIDTH-1:0]    pc_nxt;
  logic [1:0]             cc_nxt;
  logic                   taken_nxt;
  logic                   load_off;
  logic signed [7:0]      offset_p1;

  // Displacement is sign-extended past the PC width; the add wraps modulo 2^PC_WIDTH.
  function automatic logic [PC_WIDTH-1:0] branch_target(input logic [PC_WIDTH-1:0] base,
                                                        input logic signed [7:0] disp);
    logic signed [PC_WIDTH+7:0] disp_ext;
    disp_ext = (PC_WIDTH+8)'(disp);
    return base + disp_ext[PC_WIDTH-1:0];
  endfunction

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cc_nxt    = compare_control;
    taken_nxt = 1'b0;
    load_off  = 1'b0;
    if (start) begin
      state_nxt = RUN;
      pc_nxt    = PC_RST;
    end else begin
      case (state)
        RUN: begin
          if (instr_valid) begin
            if (instr_halt) begin
              state_nxt = HALTED;
            end else if (instr_branch) begin
              cc_nxt    = instr_cmp;
              load_off  = 1'b1;
              state_nxt = EVAL;
            end else begin
              pc_nxt = pc + PC_ONE;
            end
          end
        end
        EVAL: begin
          // Condition 3 is unconditional, so the comparator is ignored for it.
          if (cmp_result || (compare_control == CMP_ALWAYS)) begin
            pc_nxt    = branch_target(pc, offset_p1);
            taken_nxt = 1'b1;
          end else begin
            pc_nxt = pc + PC_ONE;
          end
          state_nxt = RUN;
        end
        default: ;
      endcase
    end
  end

  assign instr_ready = (state == RUN);
  assign halted      = (state == HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      pc              <= PC_RST;
      compare_control <= 2'd0;
      taken           <= 1'b0;
    end else begin
      state           <= state_nxt;
      pc              <= pc_nxt;
      compare_control <= cc_nxt;
      taken           <= taken_nxt;
    end
  end

  // Stage p1: branch displacement captured at acceptance, consumed in EVAL.
  always_ff @(posedge clk) begin
    if (load_off) offset_p1 <= instr_offset;
  end

`ifdef BRANCH_COUNT_EN
  logic [15:0] count_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         count_q <= 16'd0;
    else if (taken_nxt) count_q <= sat_inc(count_q);
  end

  assign taken_count = count_q;
`else
  assign taken_count = 16'd0;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_branch_sequencer;
  localparam int PCW  = 8;
  localparam int RPC  = 0;
  localparam int MASK = (1 << PCW) - 1;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              instr_valid;
  logic              instr_ready;
  logic              instr_branch;
  logic              instr_halt;
  logic [1:0]        instr_cmp;
  logic [7:0]        instr_offset;
  logic [1:0]        compare_control;
  logic              cmp_result;
  logic [PCW-1:0]    pc;
  logic              taken;
  logic              halted;
  logic [15:0]       taken_count;
  logic signed [15:0] opa, opb;
  logic              junk;

  branch_sequencer #(.PC_WIDTH(PCW), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_branch(instr_branch), .instr_halt(instr_halt),
    .instr_cmp(instr_cmp), .instr_offset(instr_offset), .compare_control(compare_control),
    .cmp_result(cmp_result), .pc(pc), .taken(taken), .halted(halted),
    .taken_count(taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signed 16-bit comparator driven by the DUT's registered condition.
  assign cmp_result = (compare_control == 2'd0) ? (opa < opb) :
                      (compare_control == 2'd1) ? (opa > opb) :
                      (compare_control == 2'd2) ? (opa == opb) : junk;

  typedef struct {
    int pc; int taken; int halted; int ready; int cc; int cnt;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;

  // Model: mode 0 idle, 1 run, 2 eval, 3 halted.
  int m_mode, m_pc, m_cc, m_off, m_taken, m_cnt;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    e.pc     = m_pc;
    e.taken  = m_taken;
    e.halted = (m_mode == 3) ? 1 : 0;
    e.ready  = (m_mode == 1) ? 1 : 0;
    e.cc     = m_cc;
`ifdef BRANCH_COUNT_EN
    e.cnt    = m_cnt;
`else
    e.cnt    = 0;
`endif
    return e;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pc = RPC; m_cc = 0; m_off = 0; m_taken = 0; m_cnt = 0;
  endtask

  function automatic bit cond_holds(input int cc, input int av, input int bv);
    if (cc == 3) return 1'b1;
    if (cc == 0) return av < bv;
    if (cc == 1) return av > bv;
    return av == bv;
  endfunction

  task automatic step(input bit st, input bit v, input bit br, input bit hl,
                      input int cmp, input int off, input int av, input int bv);
    @(negedge clk);
    start = st; instr_valid = v; instr_branch = br; instr_halt = hl;
    instr_cmp = 2'(cmp); instr_offset = 8'(off);
    opa = 16'(av); opb = 16'(bv); junk = 1'($urandom_range(0, 1));
    m_taken = 0;
    if (st) begin
      m_mode = 1; m_pc = RPC;
    end else if (m_mode == 1 && v) begin
      if (hl) m_mode = 3;
      else if (br) begin m_cc = cmp; m_off = off; m_mode = 2; end
      else m_pc = (m_pc + 1) & MASK;
    end else if (m_mode == 2) begin
      if (cond_holds(m_cc, av, bv)) begin
        m_pc = (m_pc + m_off) & MASK;
        m_taken = 1;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        m_pc = (m_pc + 1) & MASK;
      end
      m_mode = 1;
    end
    q.push_back(model_exp());
  endtask

  task automatic nb();
    step(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; instr_valid = 1'b0;
    model_reset();
    #1;
    chk("rst_pc", int'(pc), RPC);
    chk("rst_taken", int'(taken), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_ready", int'(instr_ready), 0);
    chk("rst_cc", int'(compare_control), 0);
    chk("rst_count", int'(taken_count), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc", int'(pc), e.pc);
        chk("taken", int'(taken), e.taken);
        chk("halted", int'(halted), e.halted);
        chk("instr_ready", int'(instr_ready), e.ready);
        chk("compare_control", int'(compare_control), e.cc);
        chk("taken_count", int'(taken_count), e.cnt);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int st, v, br, hl, cmp, off, av, bv;
    rst_n = 1'b0; start = 1'b0; instr_valid = 1'b0; instr_branch = 1'b0;
    instr_halt = 1'b0; instr_cmp = 2'd0; instr_offset = 8'd0;
    opa = 16'sd0; opb = 16'sd0; junk = 1'b0;
    model_reset();
    do_reset();

    // Inputs other than start are ignored while idle.
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    nb(); nb(); nb();
    settle();
    chk("seq_pc3", int'(pc), 3);
    nb(); nb();
    step(0, 1, 1, 0, 0, -3, -1, 2);
    settle();
    chk("eval_cc0", int'(compare_control), 0);
    chk("eval_ready", int'(instr_ready), 0);
    step(0, 0, 0, 0, 0, 0, -1, 2);
    settle();
    chk("back_pc2", int'(pc), 2);
    chk("back_taken", int'(taken), 1);
    nb(); nb(); nb();
    step(0, 1, 1, 0, 2, 4, 1, 2);
    step(0, 0, 0, 0, 0, 0, 1, 2);
    settle();
    chk("untaken_pc6", int'(pc), 6);
    chk("untaken_taken", int'(taken), 0);

    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 250; i++) nb();
    step(0, 1, 1, 0, 3, 10, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    settle();
    chk("wrap_pc4", int'(pc), 4);
    chk("wrap_taken", int'(taken), 1);
    step(0, 1, 1, 1, 1, 7, 0, 0);
    settle();
    chk("halt_halted", int'(halted), 1);
    chk("halt_pc", int'(pc), 4);
    chk("halt_ready", int'(instr_ready), 0);
    nb();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("restart_pc", int'(pc), RPC);
    chk("restart_ready", int'(instr_ready), 1);

    do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 3, 5, 0, 0);   step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 2, 5, 3, 4);   step(0, 0, 0, 0, 0, 0, 3, 4);
    step(0, 1, 1, 0, 0, -2, -5, 9); step(0, 0, 0, 0, 0, 0, -5, 9);
    step(0, 1, 1, 0, 1, 3, -5, 9);  step(0, 0, 0, 0, 0, 0, -5, 9);
    step(0, 1, 1, 0, 1, 3, 9, -5);  step(0, 0, 0, 0, 0, 0, 9, -5);
    settle();
`ifdef BRANCH_COUNT_EN
    chk("count_3", int'(taken_count), 3);
`else
    chk("count_tied", int'(taken_count), 0);
`endif
    // Reset lands while the branch is in EVAL.
    step(0, 1, 1, 0, 3, 20, 0, 0);
    do_reset();
    step(0, 1, 1, 0, 3, 20, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      if (m_mode == 0 || m_mode == 3) st = ($urandom_range(0, 4) == 0) ? 1 : 0;
      else st = ($urandom_range(0, 49) == 0) ? 1 : 0;
      v   = ($urandom_range(0, 9) < 7) ? 1 : 0;
      br  = ($urandom_range(0, 9) < 3) ? 1 : 0;
      hl  = ($urandom_range(0, 39) == 0) ? 1 : 0;
      cmp = int'($urandom_range(0, 3));
      off = int'($urandom_range(0, 255)) - 128;
      av  = int'($urandom_range(0, 65535)) - 32768;
      bv  = ($urandom_range(0, 3) == 0) ? av : int'($urandom_range(0, 65535)) - 32768;
      step(st[0], v[0], br[0], hl[0], cmp, off, av, bv);
    end

    @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
